perf_stat_unit: RTL and testbench

//  Hardware performance-statistics block downstream of the cpu top level.
//  - Consumes per-cycle retire/cache/halt event strobes and keeps saturating

---
 rtl/perf_pkg.sv | 20 ++
 rtl/perf_sat_counter.sv | 33 +++
 rtl/perf_stat_unit.sv | 134 +++++++++++++
 tb/tb_perf_stat_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared indices and state encodings for the performance-statistics unit.
// Read-select values double as counter-bank indices.
package perf_pkg;

  localparam logic [2:0] CNT_CYC  = 3'd0;
  localparam logic [2:0] CNT_INST = 3'd1;
  localparam logic [2:0] CNT_IREQ = 3'd2;
  localparam logic [2:0] CNT_IHIT = 3'd3;
  localparam logic [2:0] CNT_DREQ = 3'd4;
  localparam logic [2:0] CNT_DHIT = 3'd5;
  localparam logic [2:0] CNT_STAT = 3'd6;
  localparam logic [2:0] CNT_NONE = 3'd7;
  localparam int         NUM_CNT  = 6;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } perf_state_e;

endpackage

// File: rtl/perf_sat_counter.sv
// Single saturating up-counter with synchronous clear.
// Reset wins over clear, clear wins over increment.
module perf_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (inc && !(&cnt_q))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/perf_stat_unit.sv
// Performance-statistics block: halt FSM, six saturating event counters,
// registered read port. Optional shadow bank under PERF_SNAPSHOT_EN.
module perf_stat_unit
  import perf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_reg_write,
  input  logic             mem_wr,
  input  logic             hlt,
  input  logic             icache_req,
  input  logic             icache_hit,
  input  logic             dcache_req,
  input  logic             dcache_hit,
  input  logic             clear,
  input  logic             snap,
  input  logic             rd_en,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             halted
);

  perf_state_e state_q;
  logic        run;

  assign run    = (state_q == ST_RUN);
  assign halted = (state_q == ST_HALTED);

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= ST_RUN;
    else if (clear)
      state_q <= ST_RUN;
    else if (run && hlt)
      state_q <= ST_HALTED;
  end

  logic [NUM_CNT-1:0] inc;

  always_comb begin
    inc           = '0;
    inc[CNT_CYC]  = run;
    inc[CNT_INST] = run & (wb_reg_write | mem_wr | hlt);
    inc[CNT_IREQ] = run & icache_req;
    inc[CNT_IHIT] = run & icache_req & icache_hit;
    inc[CNT_DREQ] = run & dcache_req;
    inc[CNT_DHIT] = run & dcache_req & dcache_hit;
  end

  logic [CNT_W-1:0] cnt [NUM_CNT];

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    perf_sat_counter #(
      .W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clear(clear),
      .inc  (inc[g]),
      .q    (cnt[g])
    );
  end

  logic [CNT_W-1:0] src [NUM_CNT];

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] post  [NUM_CNT];
  logic [CNT_W-1:0] shd_q [NUM_CNT];

  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      post[i] = cnt[i];
      if (inc[i] && !(&cnt[i]))
        post[i] = cnt[i] + CNT_W'(1);
    end
  end

  // Under clear the cycle's events are dropped, so keep the pre-clear value
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++)
        shd_q[i] <= '0;
    end else if (snap) begin
      for (int i = 0; i < NUM_CNT; i++)
        shd_q[i] <= clear ? cnt[i] : post[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CNT; i++)
      src[i] = shd_q[i];
  end
`else
  logic unused_snap;
  assign unused_snap = snap;

  always_comb begin
    for (int i = 0; i < NUM_CNT; i++)
      src[i] = cnt[i];
  end
`endif

  logic [CNT_W-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      CNT_STAT: rd_mux = {{(CNT_W-1){1'b0}}, halted};
      CNT_NONE: rd_mux = '0;
      default:  rd_mux = src[rd_sel];
    endcase
  end

  logic [CNT_W-1:0] rd_data_q;
  logic             rd_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en)
        rd_data_q <= rd_mux;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_perf_stat_unit.sv
// Scoreboard bench for perf_stat_unit (CNT_W=8); reads push expectations,
// a monitor pops them when rd_valid is due. PERF_SNAPSHOT_EN aware.
module tb_perf_stat_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         wb_reg_write, mem_wr, hlt;
  logic         icache_req, icache_hit;
  logic         dcache_req, dcache_hit;
  logic         clear, snap, rd_en;
  logic [2:0]   rd_sel;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         halted;

  perf_stat_unit #(
    .CNT_W(W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_reg_write(wb_reg_write),
    .mem_wr      (mem_wr),
    .hlt         (hlt),
    .icache_req  (icache_req),
    .icache_hit  (icache_hit),
    .dcache_req  (dcache_req),
    .dcache_hit  (dcache_hit),
    .clear       (clear),
    .snap        (snap),
    .rd_en       (rd_en),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           due;
    logic [2:0]   sel;
    logic [W-1:0] data;
  } exp_t;

  exp_t sbq[$];
  int   ncyc  = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) ncyc = ncyc + 1;

  // Monitor: every rd_valid must match the head expectation due this cycle
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0 && sbq[0].due == ncyc) begin
      e = sbq.pop_front();
      n_cmp++;
      if (!rd_valid || rd_data !== e.data) begin
        n_err++;
        $display("FAIL read sel=%0d: got valid=%0b data=%0d, want valid=1 data=%0d",
                 e.sel, rd_valid, rd_data, e.data);
      end
    end else if (rd_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected rd_valid: got data=%0d, want no valid", rd_data);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ev_idle();
    wb_reg_write = 0; mem_wr = 0; hlt = 0;
    icache_req = 0; icache_hit = 0;
    dcache_req = 0; dcache_hit = 0;
  endtask

  task automatic rd(input logic [2:0] s, input logic [W-1:0] v);
    exp_t e;
    e.due  = ncyc + 1;
    e.sel  = s;
    e.data = v;
    sbq.push_back(e);
    rd_en  = 1'b1;
    rd_sel = s;
    tick();
    rd_en  = 1'b0;
  endtask

  task automatic do_snap();
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] got,
                     input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  initial begin
    rst = 1; clear = 0; snap = 0; rd_en = 0; rd_sel = 0;
    ev_idle();
    ticks(2);
    rst = 0;

    // Reset state
    chk("rst_halted", {7'd0, halted}, 8'd0);
    chk("rst_valid", {7'd0, rd_valid}, 8'd0);
    for (int s = 0; s < 8; s++)
      rd(3'(s), 8'd0);

    // Reset mid-operation drops an in-flight read and zeroes counters
    tick();
    rd_en = 1; rd_sel = 3'd0; rst = 1;
    tick();
    rd_en = 0;
    chk("rst_drop_valid", {7'd0, rd_valid}, 8'd0);
    tick();
    rst = 0;
    rd(3'd0, 8'd0);

    // Counting with overlaps and hits without requests
    clear = 1;
    tick();
    clear = 0;
    for (int i = 0; i < 11; i++) begin
      ev_idle();
      if (i < 10) begin
        icache_req   = 1;
        icache_hit   = (i < 7);
        wb_reg_write = (i < 4);
        mem_wr       = (i == 3 || i == 4);
        dcache_req   = (i < 3);
        dcache_hit   = (i < 2);
      end else begin
        icache_hit = 1;
        dcache_hit = 1;
      end
      tick();
    end
    ev_idle();
    do_snap();
    rd(3'd0, 8'd12);
    rd(3'd1, 8'd5);
    rd(3'd2, 8'd10);
    rd(3'd3, 8'd7);
    rd(3'd4, 8'd3);
    rd(3'd5, 8'd2);

    // Halt on cycle 20 after reset release, then freeze
    rst = 1;
    ticks(2);
    rst = 0;
    for (int i = 0; i < 19; i++) begin
      wb_reg_write = (i % 5 == 0);
      tick();
    end
    wb_reg_write = 0;
    hlt = 1;
    tick();
    hlt = 0;
    chk("halt_flag", {7'd0, halted}, 8'd1);
    wb_reg_write = 1; mem_wr = 1; hlt = 1;
    icache_req = 1; icache_hit = 1;
    dcache_req = 1; dcache_hit = 1;
    ticks(50);
    ev_idle();
    do_snap();
    rd(3'd0, 8'd20);
    rd(3'd1, 8'd5);
    rd(3'd2, 8'd0);
    rd(3'd5, 8'd0);
    rd(3'd6, 8'd1);
    rd(3'd7, 8'd0);
    chk("halt_sticky", {7'd0, halted}, 8'd1);

    // Saturation at 8 bits
    clear = 1;
    tick();
    clear = 0;
    icache_req = 1;
    ticks(300);
    icache_req = 0;
    do_snap();
    rd(3'd0, 8'd255);
    rd(3'd2, 8'd255);
    rd(3'd6, 8'd0);
    ticks(10);
    do_snap();
    rd(3'd0, 8'd255);

    // Clear beats halt and retire in the same cycle
    clear = 1; hlt = 1; wb_reg_write = 1;
    tick();
    clear = 0; hlt = 0; wb_reg_write = 0;
    chk("clr_halted", {7'd0, halted}, 8'd0);
    do_snap();
    rd(3'd0, 8'd1);
    rd(3'd1, 8'd0);
    rd(3'd6, 8'd0);

    // Snapshot at CYC=9, read five cycles later
    clear = 1;
    tick();
    clear = 0;
    ticks(8);
    do_snap();
    ticks(5);
`ifdef PERF_SNAPSHOT_EN
    rd(3'd0, 8'd9);
`else
    rd(3'd0, 8'd14);
`endif

    ticks(3);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending reads, want 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
